// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg
//   Shared op codes, FSM state encodings and small decode helpers for the
//   EX-stage multiply/divide sequencer.
//   Ports: none (package).
//   Optional feature macro used by importers: MULDIV_FAST_MUL_EN.
package ex_muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_MULTU = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_DIVU  = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_datapath.sv
// ex_muldiv_ctrl_datapath
//   Iterative unsigned datapath: one shift-add multiply step or one restoring
//   divide step per enabled cycle. Operates on magnitudes only; signs are
//   handled by the controller.
//   Ports:
//     clk, rst       clock / synchronous active-high reset
//     load           capture operands and mode (controller accept cycle)
//     step           advance one iteration
//     div_mode       1 = divide, 0 = multiply (sampled on load)
//     op_a           rs magnitude (multiplicand / dividend)
//     op_b           rt magnitude (multiplier / divisor)
//     step_result    value the partial register takes on this step
//                    mul: {hi,lo} product, div: {remainder,quotient}
//   Feature macro: none here (MULDIV_FAST_MUL_EN lives in the top).
module ex_muldiv_ctrl_datapath #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  div_mode,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic [2*DATA_W-1:0]   step_result
);

  logic [DATA_W-1:0]   a_reg;      // multiplicand or divisor
  logic [2*DATA_W-1:0] p_reg;      // {acc, multiplier} or {rem, dividend/quotient}
  logic                div_reg;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_shift;
  logic                rem_ge;
  logic [DATA_W-1:0]   rem_new;

  always_comb begin
    // Multiply: add multiplicand into upper half when the current LSB is set,
    // then shift the whole {carry, acc, multiplier} right by one.
    mul_sum = {1'b0, p_reg[2*DATA_W-1:DATA_W]} + (p_reg[0] ? {1'b0, a_reg} : '0);

    // Divide: shift next dividend bit into the remainder and try to subtract.
    // A set top bit means the shifted remainder already exceeds any W-bit divisor.
    rem_shift = {p_reg[2*DATA_W-1:DATA_W], p_reg[DATA_W-1]};
    rem_ge    = rem_shift[DATA_W] | (rem_shift[DATA_W-1:0] >= a_reg);
    // True difference is < divisor, so modulo-2^W arithmetic is exact.
    rem_new   = rem_ge ? (rem_shift[DATA_W-1:0] - a_reg) : rem_shift[DATA_W-1:0];

    if (div_reg) begin
      step_result = {rem_new, p_reg[DATA_W-2:0], rem_ge};
    end else begin
      step_result = {mul_sum, p_reg[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      p_reg   <= '0;
      div_reg <= 1'b0;
    end else if (load) begin
      div_reg <= div_mode;
      if (div_mode) begin
        a_reg <= op_b;
        p_reg <= {{DATA_W{1'b0}}, op_a};
      end else begin
        a_reg <= op_a;
        p_reg <= {{DATA_W{1'b0}}, op_b};
      end
    end else if (step) begin
      p_reg <= step_result;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl
//   EX-stage multiply/divide sequencer and owner of HI/LO. Accepts
//   MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs a DATA_W-iteration shift-add multiply
//   or restoring divide, stalls the pipeline until HI/LO are written.
//   Ports:
//     clk, rst        clock / synchronous active-high reset
//     W_MD_start      EX holds a md instruction (level, held while stalled)
//     W_MD_op         op code (MD_OP_*)
//     W_MD_rs_data    rs operand (dividend / multiplicand / MT source)
//     W_MD_rt_data    rt operand (divisor / multiplier)
//     W_MD_flush      abort request
//     W_MD_stall      freeze IF/ID/EX
//     W_MD_busy       state != IDLE
//     W_MD_hi/W_MD_lo registered HI/LO
//   Macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle at accept with
//   no stall; divides remain iterative.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              W_MD_start,
  input  logic [2:0]        W_MD_op,
  input  logic [DATA_W-1:0] W_MD_rs_data,
  input  logic [DATA_W-1:0] W_MD_rt_data,
  input  logic              W_MD_flush,
  output logic              W_MD_stall,
  output logic              W_MD_busy,
  output logic [DATA_W-1:0] W_MD_hi,
  output logic [DATA_W-1:0] W_MD_lo
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  md_state_e          state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]  hi_reg;
  logic [DATA_W-1:0]  lo_reg;
  logic               neg_res_reg;   // product / quotient must be negated
  logic               neg_rem_reg;   // remainder takes the dividend's sign
  logic               div_reg;
  logic               div0_reg;

  logic               rs_neg;
  logic               rt_neg;
  logic [DATA_W-1:0]  rs_mag;
  logic [DATA_W-1:0]  rt_mag;
  logic               iter_accept;
  logic               step_en;
  logic [2*DATA_W-1:0] step_result;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]  fix_hi;
  logic [DATA_W-1:0]  fix_lo;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_a;
  logic [2*DATA_W-1:0] fast_b;
  logic [2*DATA_W-1:0] fast_prod;
`endif

  always_comb begin
    rs_neg = md_is_signed(W_MD_op) & W_MD_rs_data[DATA_W-1];
    rt_neg = md_is_signed(W_MD_op) & W_MD_rt_data[DATA_W-1];
    rs_mag = rs_neg ? (~W_MD_rs_data + 1'b1) : W_MD_rs_data;
    rt_mag = rt_neg ? (~W_MD_rt_data + 1'b1) : W_MD_rt_data;

`ifdef MULDIV_FAST_MUL_EN
    iter_accept = (state_reg == MD_ST_IDLE) & W_MD_start & ~W_MD_flush & md_is_div(W_MD_op);
    // Sign-extending to 2W bits makes the low 2W bits of the product correct
    // for both signed and unsigned operands.
    fast_a = md_is_signed(W_MD_op) ? {{DATA_W{W_MD_rs_data[DATA_W-1]}}, W_MD_rs_data}
                                   : {{DATA_W{1'b0}}, W_MD_rs_data};
    fast_b = md_is_signed(W_MD_op) ? {{DATA_W{W_MD_rt_data[DATA_W-1]}}, W_MD_rt_data}
                                   : {{DATA_W{1'b0}}, W_MD_rt_data};
    fast_prod = fast_a * fast_b;
`else
    iter_accept = (state_reg == MD_ST_IDLE) & W_MD_start & ~W_MD_flush &
                  (md_is_mul(W_MD_op) | md_is_div(W_MD_op));
`endif

    step_en = (state_reg == MD_ST_CALC) & ~W_MD_flush;

    // Sign fix-up applied to the final iteration's value.
    prod_fix = neg_res_reg ? (~step_result + 1'b1) : step_result;
    if (div_reg) begin
      // A zero divisor leaves an all-ones quotient and the dividend as
      // remainder; skipping quotient negation keeps LO all ones, and the
      // remainder sign fix-up restores the original rs.
      fix_lo = (div0_reg | ~neg_res_reg) ? step_result[DATA_W-1:0]
                                         : (~step_result[DATA_W-1:0] + 1'b1);
      fix_hi = neg_rem_reg ? (~step_result[2*DATA_W-1:DATA_W] + 1'b1)
                           : step_result[2*DATA_W-1:DATA_W];
    end else begin
      fix_lo = prod_fix[DATA_W-1:0];
      fix_hi = prod_fix[2*DATA_W-1:DATA_W];
    end
  end

  ex_muldiv_ctrl_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (iter_accept),
    .step        (step_en),
    .div_mode    (md_is_div(W_MD_op)),
    .op_a        (rs_mag),
    .op_b        (rt_mag),
    .step_result (step_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= MD_ST_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div_reg     <= 1'b0;
      div0_reg    <= 1'b0;
    end else begin
      case (state_reg)
        MD_ST_IDLE: begin
          if (iter_accept) begin
            state_reg   <= MD_ST_CALC;
            cnt_reg     <= '0;
            neg_res_reg <= rs_neg ^ rt_neg;
            neg_rem_reg <= rs_neg;
            div_reg     <= md_is_div(W_MD_op);
            div0_reg    <= (W_MD_rt_data == '0);
          end else if (W_MD_start && !W_MD_flush) begin
            case (W_MD_op)
              MD_OP_MTHI: hi_reg <= W_MD_rs_data;
              MD_OP_MTLO: lo_reg <= W_MD_rs_data;
`ifdef MULDIV_FAST_MUL_EN
              MD_OP_MULT, MD_OP_MULTU: {hi_reg, lo_reg} <= fast_prod;
`endif
              default: ;
            endcase
          end
        end
        MD_ST_CALC: begin
          if (W_MD_flush) begin
            state_reg <= MD_ST_IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            hi_reg    <= fix_hi;
            lo_reg    <= fix_lo;
            state_reg <= MD_ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        // One cycle with stall low lets the held instruction retire once.
        MD_ST_DONE: state_reg <= MD_ST_IDLE;
        default:    state_reg <= MD_ST_IDLE;
      endcase
    end
  end

  assign W_MD_stall = iter_accept | (state_reg == MD_ST_CALC);
  assign W_MD_busy  = (state_reg != MD_ST_IDLE);
  assign W_MD_hi    = hi_reg;
  assign W_MD_lo    = lo_reg;

endmodule
